// File: rtl/param_stack.sv
// param_stack: parametrised LIFO stack with registered pop data.
//
// Holds up to DEPTH words of DATA_W bits. A pop presents the top word on
// data_out one clock later with a single-cycle valid_out strobe; data_out
// holds between pops. Push and pop together replace the top entry.
// Rejected pushes (full) and pops (empty) raise overflow / underflow.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset (control state and data_out)
//   push       write data_in onto the stack
//   pop        remove the top entry
//   data_in    word to push
//   err_clr    clears sticky error flags (only with PARAM_STACK_STICKY_ERR_EN)
//   data_out   registered popped word
//   valid_out  data_out updated this cycle
//   count      number of stored entries (0..DEPTH)
//   full       count == DEPTH
//   empty      count == 0
//   overflow   push rejected because full
//   underflow  pop rejected because empty
//
// Build option: define PARAM_STACK_STICKY_ERR_EN to make overflow/underflow
// sticky until rst or err_clr. Without it they are one-cycle pulses.
module param_stack #(
  parameter  int DATA_W = 4,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
`ifdef PARAM_STACK_STICKY_ERR_EN
  input  logic              err_clr,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     sp_addr;
  logic [AW-1:0]     top_addr;
  logic              ovf_evt;
  logic              unf_evt;

  // sp == count; the top entry sits one below it. Both only index memory
  // when they are in range (not full / not empty respectively).
  assign sp_addr  = AW'(cnt_q);
  assign top_addr = AW'(cnt_q - 1'b1);

  always_comb begin
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = sp_addr;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;

    if (push && pop) begin
      if (!empty_q) begin
        // Replace-top: read old top and overwrite it in the same edge.
        dout_d  = mem[top_addr];
        vld_d   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = top_addr;
      end else begin
        // Nothing to pop, but the push still lands in slot 0.
        wr_en   = 1'b1;
        wr_addr = sp_addr;
        cnt_d   = cnt_q + 1'b1;
        unf_evt = 1'b1;
      end
    end else if (push) begin
      if (full_q) begin
        ovf_evt = 1'b1;
      end else begin
        wr_en   = 1'b1;
        wr_addr = sp_addr;
        cnt_d   = cnt_q + 1'b1;
      end
    end else if (pop) begin
      if (empty_q) begin
        unf_evt = 1'b1;
      end else begin
        dout_d = mem[top_addr];
        vld_d  = 1'b1;
        cnt_d  = cnt_q - 1'b1;
      end
    end

    full_d  = (cnt_d == CNT_MAX);
    empty_d = (cnt_d == '0);

`ifdef PARAM_STACK_STICKY_ERR_EN
    // A new error in the clearing cycle wins over err_clr.
    ovf_d = ovf_evt | (ovf_q & ~err_clr);
    unf_d = unf_evt | (unf_q & ~err_clr);
`else
    ovf_d = ovf_evt;
    unf_d = unf_evt;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is never reset; a write is suppressed while rst is high so a
  // push issued with reset leaves no trace.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_addr] <= data_in;
    end
  end

  assign data_out  = dout_q;
  assign valid_out = vld_q;
  assign count     = cnt_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

`ifdef PARAM_STACK_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] data_in;
  logic              err_clr;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  param_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .data_in   (data_in),
`ifdef PARAM_STACK_STICKY_ERR_EN
    .err_clr   (err_clr),
`endif
    .data_out  (data_out),
    .valid_out (valid_out),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic step(input logic pu, input logic po, input logic [DATA_W-1:0] d,
                      input logic r, input logic clr);
    push    = pu;
    pop     = po;
    data_in = d;
    rst     = r;
    err_clr = clr;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    rst     = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic do_push(input logic [DATA_W-1:0] d);
    step(1'b1, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic do_pop();
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic clear_err();
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0; err_clr = 1'b0;

    // Reset then idle
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_dout", data_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);

    // Fill with 1..8
    for (int i = 1; i <= DEPTH; i++) begin
      do_push(DATA_W'(i));
      check($sformatf("fill_count_%0d", i), count, i);
      check($sformatf("fill_full_%0d", i), full, (i == DEPTH) ? 1 : 0);
      check($sformatf("fill_empty_%0d", i), empty, 0);
    end

    // Overflow at full
    do_push(4'hF);
    check("ovf_pulse", overflow, 1);
    check("ovf_count", count, DEPTH);
    check("ovf_full", full, 1);
    check("ovf_valid", valid_out, 0);
    idle();
    check("ovf_after_idle", overflow, STICKY ? 1 : 0);
    clear_err();
    check("ovf_cleared", overflow, 0);

    // Drain: expect 8,7,...,1 (the rejected F never entered)
    for (int i = DEPTH; i >= 1; i--) begin
      do_pop();
      check($sformatf("drain_data_%0d", i), data_out, i);
      check($sformatf("drain_valid_%0d", i), valid_out, 1);
      check($sformatf("drain_count_%0d", i), count, i - 1);
    end
    check("drain_empty", empty, 1);
    idle();
    check("valid_drops", valid_out, 0);
    check("dout_holds", data_out, 1);

    // Underflow on pop of empty stack
    do_pop();
    check("unf_pulse", underflow, 1);
    check("unf_valid", valid_out, 0);
    check("unf_dout_hold", data_out, 1);
    check("unf_count", count, 0);
    clear_err();
    check("unf_cleared", underflow, 0);

    // Push+pop when empty: push lands, pop rejected
    step(1'b1, 1'b1, 4'h5, 1'b0, 1'b0);
    check("pp_empty_count", count, 1);
    check("pp_empty_unf", underflow, 1);
    check("pp_empty_valid", valid_out, 0);
    check("pp_empty_dout", data_out, 1);
    clear_err();
    do_pop();
    check("pp_empty_pop_data", data_out, 5);
    check("pp_empty_pop_valid", valid_out, 1);
    check("pp_empty_pop_empty", empty, 1);

    // Replace-top: 3,7 then push+pop 9
    do_push(4'h3);
    do_push(4'h7);
    step(1'b1, 1'b1, 4'h9, 1'b0, 1'b0);
    check("rt_data", data_out, 7);
    check("rt_valid", valid_out, 1);
    check("rt_count", count, 2);
    do_pop();
    check("rt_pop1", data_out, 9);
    do_pop();
    check("rt_pop2", data_out, 3);
    check("rt_empty", empty, 1);

    // Replace-top at full: no overflow
    for (int i = 1; i <= DEPTH; i++) do_push(DATA_W'(i));
    step(1'b1, 1'b1, 4'hA, 1'b0, 1'b0);
    check("rtf_data", data_out, DEPTH);
    check("rtf_ovf", overflow, 0);
    check("rtf_count", count, DEPTH);
    check("rtf_full", full, 1);
    do_pop();
    check("rtf_pop", data_out, 4'hA);
    check("rtf_pop_full", full, 0);

    // Reset mid-operation, with a push in the reset cycle
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    do_push(4'h1);
    do_push(4'h2);
    do_push(4'h3);
    check("mid_pre_count", count, 3);
    step(1'b1, 1'b0, 4'hC, 1'b1, 1'b0);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_dout", data_out, 0);
    do_push(4'h6);
    do_pop();
    check("mid_rst_fresh", data_out, 6);
    check("mid_rst_fresh_empty", empty, 1);

    // Error flag behaviour with and without err_clr, plus clear-vs-new priority
    for (int i = 1; i <= DEPTH; i++) do_push(DATA_W'(i));
    do_push(4'hE);
    check("err_ovf_set", overflow, 1);
    idle();
    idle();
    check("err_ovf_hold", overflow, STICKY ? 1 : 0);
    step(1'b1, 1'b0, 4'hE, 1'b0, 1'b1);
    check("err_clr_vs_new", overflow, 1);
    clear_err();
    check("err_ovf_clr", overflow, 0);
    check("err_count", count, DEPTH);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO stack: configurable data width and depth, registered pop data with a valid strobe, occupancy count, and overflow/underflow reporting.
- Supports push and pop in the same cycle as a replace-top operation.
- Used as the generic stack primitive in lab datapaths (expression evaluators, call/return buffers); replaces the fixed 4-bit x 8 stack.

Parameters:
- DATA_W, 4, width of each stored word.
- DEPTH, 8, number of entries; must be >= 2.
- CNT_W, $clog2(DEPTH+1), local/derived; width of the occupancy count (holds 0..DEPTH).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  write data_in onto the stack this cycle.
- pop  in  1  remove the top entry this cycle.
- data_in  in  DATA_W  word to push.
- data_out  out  DATA_W  registered popped word; holds its value between pops.
- valid_out  out  1  one-cycle pulse: data_out was updated this cycle.
- count  out  CNT_W  current number of stored entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0 (active-high: 1 means empty).
- overflow  out  1  one-cycle pulse: push rejected because the stack was full.
- underflow  out  1  one-cycle pulse: pop rejected because the stack was empty.

Behaviour:
- Reset: sampled on the clk rising edge while rst=1.
  - Outputs after reset: count=0, empty=1, full=0, data_out=0, valid_out=0, overflow=0, underflow=0.
  - Memory contents are not cleared and are not observable.
  - Reset overrides any push/pop issued in the same cycle.
- Storage: sp (CNT_W bits) equals count and points to the next free slot.
- Operation on each cycle with rst=0, evaluated against the pre-edge state:
  - push only, not full: mem[sp] <= data_in; count +1.
  - push only, full: no write; count unchanged; overflow=1 for one cycle.
  - pop only, not empty: data_out <= mem[sp-1]; valid_out=1; count -1.
  - pop only, empty: data_out holds; valid_out=0; underflow=1 for one cycle.
  - push+pop, not empty: data_out <= mem[sp-1]; mem[sp-1] <= data_in; valid_out=1; count unchanged. Legal when full; no overflow.
  - push+pop, empty: the push is performed (count becomes 1); the pop is rejected with underflow=1; valid_out=0.
  - neither: all state holds; valid_out, overflow and underflow are 0.
- Latency: pop data appears on data_out one clock after the pop edge. full, empty and count reflect the post-operation state in the same registered update.
- Flags are registered and never glitch.
- count never leaves 0..DEPTH; there is no wrap-around.
- A reset asserted mid-sequence discards all stored entries.

Optional Feature:
- Macro: PARAM_STACK_STICKY_ERR_EN.
- Defined:
  - overflow and underflow become sticky: once set they stay 1 until rst or err_clr.
  - Adds input port err_clr (1 bit). err_clr=1 clears both flags at the next edge; a new error in that same cycle takes priority and keeps its flag set.
- Undefined: no err_clr port; overflow and underflow are single-cycle pulses as described under Behaviour.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then rst=0 -> count=0, empty=1, full=0, data_out=0, all pulses 0.
- Fill/drain (DEPTH=8, DATA_W=4): push 1..8 -> full=1 after 8th edge, count=8. Pop 8 times -> data_out sequence 8,7,...,1, valid_out=1 each pop, then empty=1.
- Overflow: when full, push 4'hF -> overflow=1 for one cycle, count stays 8. Next pop returns 8, not F.
- Underflow: when empty, pop -> underflow=1, valid_out=0, data_out holds its previous value. Push+pop with data_in=5 when empty -> count=1, underflow=1; the next pop returns 5.
- Replace-top: stack holds 3,7 (7 on top); push+pop with data_in=9 -> data_out=7, valid_out=1, count=2. Next pop returns 9, then 3. Repeat at full -> no overflow.
- Reset mid-operation: push 3 words, assert rst together with push -> count=0 and empty=1 next cycle. With PARAM_STACK_STICKY_ERR_EN defined: overflow holds until err_clr=1, then clears.
